// File: rtl/spi_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_pkg
// Purpose  : Opcodes, FSM states and status layout for the SPI memory responder
// Revision : 1.0 - initial release
// ============================================================================
package spi_mem_pkg;

   localparam logic [7:0] c_OP_WREN  = 8'h06;
   localparam logic [7:0] c_OP_READ  = 8'h03;
   localparam logic [7:0] c_OP_WRITE = 8'h02;
   localparam logic [7:0] c_OP_RDSR  = 8'h05;
   localparam logic [7:0] c_OP_STORE = 8'h3C;

   localparam int c_STATUS_WEL_BIT = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WDATA  = 3'd3,
      ST_RDATA  = 3'd4,
      ST_STATUS = 3'd5,
      ST_IGNORE = 3'd6
   } state_t;

   function automatic logic [7:0] status_byte(input logic wel_bit);
      logic [7:0] s;
      s = 8'h00;
      s[c_STATUS_WEL_BIT] = wel_bit;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_memory_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync_edge
// Purpose  : Two-flop synchronizer with rise/fall pulses on the synced level
// Revision : 1.0 - initial release
// ============================================================================
module spi_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= din;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign rise = r_sync & ~r_prev;
   assign fall = ~r_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_memory_responder
// Purpose  : SPI mode-0 target turning WREN/READ/WRITE/RDSR/STORE into 16-bit
//            parallel memory accesses, all oversampled on clk
// Revision : 1.0 - initial release
// ============================================================================
module spi_memory_responder
   import spi_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   output logic        mem_re,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        store_pulse,
   output logic        wel,
   output logic        cmd_error
);

   logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic r_mosi_meta, r_mosi_sync;

   spi_sync_edge u_sck_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sck),
      .rise    (w_sck_rise),
      .fall    (w_sck_fall)
   );

   spi_sync_edge u_cs_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (cs),
      .rise    (w_cs_rise),
      .fall    (w_cs_fall)
   );

   state_t      r_state, w_state_next;
   logic [3:0]  r_bit_cnt, w_bit_cnt;
   logic [15:0] r_shift_in, w_shift_in;
   logic [15:0] r_shift_out, w_shift_out;
   logic [15:0] r_addr, w_addr;
   logic        r_is_read, w_is_read;
   logic        r_wel, w_wel;
   logic        r_wrote, w_wrote;
   logic        r_load;
   logic        r_miso, w_miso;
   logic        r_miso_oe, w_miso_oe;
   logic        r_mem_re, w_mem_re;
   logic        r_mem_we, w_mem_we;
   logic [15:0] r_mem_addr, w_mem_addr;
   logic [15:0] r_mem_wdata, w_mem_wdata;
   logic        r_store, w_store;
   logic        r_cmd_err, w_cmd_err;

   logic [15:0] w_word;
   logic [15:0] w_out_word;

   assign w_word     = {r_shift_in[14:0], r_mosi_sync};
   // Read data may arrive in the same cycle as the sck fall that shifts it out
   assign w_out_word = r_load ? mem_rdata : r_shift_out;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_bit_cnt    = r_bit_cnt;
      w_shift_in   = r_shift_in;
      w_shift_out  = r_shift_out;
      w_addr       = r_addr;
      w_is_read    = r_is_read;
      w_wel        = r_wel;
      w_wrote      = r_wrote;
      w_miso       = r_miso;
      w_miso_oe    = r_miso_oe;
      w_mem_re     = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_addr   = r_mem_addr;
      w_mem_wdata  = r_mem_wdata;
      w_store      = 1'b0;
      w_cmd_err    = 1'b0;

      if (r_load) begin
         w_shift_out = mem_rdata;
      end
      if (w_sck_rise) begin
         w_shift_in = w_word;
      end

      if (w_cs_rise) begin
         w_state_next = ST_IDLE;
         w_miso       = 1'b0;
         w_miso_oe    = 1'b0;
         if (r_state == ST_WDATA && r_wrote) begin
            w_wel = 1'b0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cs_fall) begin
                  w_state_next = ST_CMD;
                  w_bit_cnt    = 4'd0;
                  w_wrote      = 1'b0;
               end
            end
            ST_CMD: begin
               if (w_sck_rise) begin
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd7) begin
                     w_bit_cnt = 4'd0;
                     case (w_word[7:0])
                        c_OP_WREN: begin
                           w_wel        = 1'b1;
                           w_state_next = ST_IGNORE;
                        end
                        c_OP_STORE: begin
                           w_store      = 1'b1;
                           w_state_next = ST_IGNORE;
                        end
                        c_OP_RDSR: begin
                           w_shift_out  = {status_byte(r_wel), 8'h00};
                           w_state_next = ST_STATUS;
                        end
                        c_OP_READ: begin
                           w_is_read    = 1'b1;
                           w_state_next = ST_ADDR;
                        end
                        c_OP_WRITE: begin
                           w_is_read    = 1'b0;
                           w_state_next = ST_ADDR;
                        end
                        default: begin
                           w_cmd_err    = 1'b1;
                           w_state_next = ST_IGNORE;
                        end
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (w_sck_rise) begin
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd15) begin
                     w_bit_cnt = 4'd0;
                     w_addr    = w_word;
                     if (r_is_read) begin
                        w_mem_re     = 1'b1;
                        w_mem_addr   = w_word;
                        w_state_next = ST_RDATA;
                     end else begin
                        w_state_next = ST_WDATA;
                     end
                  end
               end
            end
            ST_WDATA: begin
               if (w_sck_rise) begin
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd15) begin
                     w_bit_cnt = 4'd0;
                     if (r_wel) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = r_addr;
                        w_mem_wdata = w_word;
                        w_addr      = r_addr + 16'd1;
                        w_wrote     = 1'b1;
                     end else begin
                        w_cmd_err   = 1'b1;
                     end
                  end
               end
            end
            ST_RDATA: begin
               if (w_sck_fall) begin
                  w_miso      = w_out_word[15];
                  w_miso_oe   = 1'b1;
                  w_shift_out = {w_out_word[14:0], 1'b0};
               end
               if (w_sck_rise) begin
                  w_bit_cnt = r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd15) begin
                     w_bit_cnt  = 4'd0;
                     w_addr     = r_addr + 16'd1;
                     w_mem_re   = 1'b1;
                     w_mem_addr = r_addr + 16'd1;
                  end
               end
            end
            ST_STATUS: begin
               // Counts falls: eight status bits, then the line goes quiet
               if (w_sck_fall) begin
                  if (r_bit_cnt < 4'd8) begin
                     w_miso      = r_shift_out[15];
                     w_miso_oe   = 1'b1;
                     w_shift_out = {r_shift_out[14:0], 1'b0};
                     w_bit_cnt   = r_bit_cnt + 4'd1;
                  end else begin
                     w_miso    = 1'b0;
                     w_miso_oe = 1'b0;
                  end
               end
            end
            ST_IGNORE: begin
               w_state_next = ST_IGNORE;
            end
            default: begin
               w_state_next = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
         r_bit_cnt   <= 4'd0;
         r_shift_in  <= 16'h0000;
         r_shift_out <= 16'h0000;
         r_addr      <= 16'h0000;
         r_is_read   <= 1'b0;
         r_wel       <= 1'b0;
         r_wrote     <= 1'b0;
         r_load      <= 1'b0;
         r_miso      <= 1'b0;
         r_miso_oe   <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 16'h0000;
         r_mem_wdata <= 16'h0000;
         r_store     <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         r_mosi_meta <= mosi;
         r_mosi_sync <= r_mosi_meta;
         r_bit_cnt   <= w_bit_cnt;
         r_shift_in  <= w_shift_in;
         r_shift_out <= w_shift_out;
         r_addr      <= w_addr;
         r_is_read   <= w_is_read;
         r_wel       <= w_wel;
         r_wrote     <= w_wrote;
         r_load      <= r_mem_re;
         r_miso      <= w_miso;
         r_miso_oe   <= w_miso_oe;
         r_mem_re    <= w_mem_re;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_store     <= w_store;
         r_cmd_err   <= w_cmd_err;
      end
   end

   assign miso        = r_miso;
   assign miso_oe     = r_miso_oe;
   assign mem_re      = r_mem_re;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign store_pulse = r_store;
   assign wel         = r_wel;
   assign cmd_error   = r_cmd_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_memory_responder
// Purpose  : Directed self-checking bench for spi_memory_responder
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_memory_responder;
   import spi_mem_pkg::*;

   localparam int HALF = 6;

   logic        clk       = 1'b0;
   logic        reset_n   = 1'b0;
   logic        cs        = 1'b1;
   logic        sck       = 1'b0;
   logic        mosi      = 1'b0;
   logic [15:0] mem_rdata = 16'h0000;
   logic        miso, miso_oe, mem_re, mem_we, store_pulse, wel, cmd_error;
   logic [15:0] mem_addr, mem_wdata;

   int          checks    = 0;
   int          errors    = 0;
   int          we_cnt    = 0;
   int          re_cnt    = 0;
   int          store_cnt = 0;
   int          err_cnt   = 0;
   logic [15:0] we_addr   = 16'h0000;
   logic [15:0] we_data   = 16'h0000;
   logic        overlap   = 1'b0;
   logic [15:0] re_addrs[$];
   logic [63:0] rx, oe;

   spi_memory_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cs          (cs),
      .sck         (sck),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .mem_re      (mem_re),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .store_pulse (store_pulse),
      .wel         (wel),
      .cmd_error   (cmd_error)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_model(input logic [15:0] a);
      case (a)
         16'hFFFF: return 16'hA5A5;
         16'h0000: return 16'h5A5A;
         default:  return 16'h0F0F;
      endcase
   endfunction

   // Strobe monitor and one-cycle-latency memory
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt++;
         we_addr = mem_addr;
         we_data = mem_wdata;
      end
      if (mem_re) begin
         re_cnt++;
         re_addrs.push_back(mem_addr);
         mem_rdata = mem_model(mem_addr);
      end
      if (store_pulse) store_cnt++;
      if (cmd_error) err_cnt++;
      if (mem_re && mem_we) overlap = 1'b1;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cs_start();
      cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_end();
      repeat (3) @(negedge clk);
      cs = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic xfer(input logic [63:0] tx, input int nbits,
                       output logic [63:0] rxv, output logic [63:0] oev);
      rxv = 64'h0;
      oev = 64'h0;
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = tx[i];
         repeat (HALF) @(negedge clk);
         rxv[i] = miso;
         oev[i] = miso_oe;
         sck = 1'b1;
         repeat (HALF) @(negedge clk);
         sck = 1'b0;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("rst_ctrl", 64'({miso, miso_oe, mem_re, mem_we, store_pulse, wel, cmd_error}), 64'd0);
      check("rst_addr", 64'(mem_addr), 64'h0);
      check("rst_wdata", 64'(mem_wdata), 64'h0);
      check("rst_state", 64'(dut.r_state), 64'(ST_IDLE));

      // WREN then WRITE 0x0010 <- 0xBEEF
      cs_start(); xfer(64'h06, 8, rx, oe); cs_end();
      check("wren_wel", 64'(wel), 64'd1);
      cs_start(); xfer({24'h0, 8'h02, 16'h0010, 16'hBEEF}, 40, rx, oe);
      repeat (4) @(negedge clk);
      check("wr_we_cnt", 64'(we_cnt), 64'd1);
      check("wr_addr", 64'(we_addr), 64'h0010);
      check("wr_data", 64'(we_data), 64'hBEEF);
      check("wr_wel_held", 64'(wel), 64'd1);
      cs_end();
      check("wr_wel_clr", 64'(wel), 64'd0);

      // WRITE without WREN
      cs_start(); xfer({24'h0, 8'h02, 16'h0020, 16'h1234}, 40, rx, oe);
      repeat (4) @(negedge clk);
      check("blk_we_cnt", 64'(we_cnt), 64'd1);
      check("blk_err_cnt", 64'(err_cnt), 64'd1);
      cs_end();
      check("blk_wel", 64'(wel), 64'd0);

      // READ 0xFFFF, 32 data clocks, address wraps
      cs_start(); xfer({40'h0, 8'h03, 16'hFFFF}, 24, rx, oe);
      xfer(64'h0, 32, rx, oe);
      check("rd_data", 64'(rx[31:0]), 64'hA5A55A5A);
      check("rd_oe", 64'(oe[31:0]), 64'hFFFFFFFF);
      cs_end();
      check("rd_oe_drop", 64'(miso_oe), 64'd0);
      check("rd_re_cnt", 64'(re_cnt), 64'd3);
      check("rd_size", 64'(re_addrs.size()), 64'd3);
      if (re_addrs.size() == 3) begin
         check("rd_addr0", 64'(re_addrs[0]), 64'hFFFF);
         check("rd_addr1", 64'(re_addrs[1]), 64'h0000);
         check("rd_addr2", 64'(re_addrs[2]), 64'h0001);
      end

      // RDSR after WREN
      cs_start(); xfer(64'h06, 8, rx, oe); cs_end();
      cs_start(); xfer(64'h0500, 16, rx, oe);
      check("rdsr_data", 64'(rx[15:0]), 64'h0001);
      check("rdsr_oe", 64'(oe[15:0]), 64'h00FF);
      xfer(64'h0, 8, rx, oe);
      check("rdsr_tail_oe", 64'(oe[7:0]), 64'h00);
      check("rdsr_tail_data", 64'(rx[7:0]), 64'h00);
      cs_end();

      // STORE and unknown opcode
      cs_start(); xfer(64'h3C, 8, rx, oe); cs_end();
      check("store_cnt", 64'(store_cnt), 64'd1);
      cs_start(); xfer(64'hFF, 8, rx, oe); cs_end();
      check("ff_err_cnt", 64'(err_cnt), 64'd2);
      check("ff_we_cnt", 64'(we_cnt), 64'd1);
      check("ff_re_cnt", 64'(re_cnt), 64'd3);
      check("ff_store_cnt", 64'(store_cnt), 64'd1);

      // WREN + WRITE aborted after 10 data bits
      cs_start(); xfer(64'h06, 8, rx, oe); cs_end();
      cs_start(); xfer({30'h0, 8'h02, 16'h0030, 10'h2AB}, 34, rx, oe); cs_end();
      check("part_we_cnt", 64'(we_cnt), 64'd1);
      check("part_state", 64'(dut.r_state), 64'(ST_IDLE));
      check("part_wel", 64'(wel), 64'd1);

      // Reset in the middle of a READ
      cs_start(); xfer({40'h0, 8'h03, 16'h0040}, 24, rx, oe);
      xfer(64'h0, 4, rx, oe);
      check("mid_oe", 64'(miso_oe), 64'd1);
      check("mid_addr", 64'(mem_addr), 64'h0040);
      reset_n = 1'b0;
      #1;
      check("mrst_ctrl", 64'({miso, miso_oe, mem_re, mem_we, store_pulse, wel, cmd_error}), 64'd0);
      check("mrst_addr", 64'(mem_addr), 64'h0);
      check("mrst_wdata", 64'(mem_wdata), 64'h0);
      check("mrst_state", 64'(dut.r_state), 64'(ST_IDLE));
      repeat (3) @(negedge clk);
      cs = 1'b1;
      reset_n = 1'b1;
      repeat (8) @(negedge clk);

      check("re_we_overlap", 64'(overlap), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
